decode_stage_pipe: RTL
======================

Name: decode_stage_pipe

Overview:
- Parametrised successor to the multicycle decode stage.
- Contains a register file of configurable width and depth, plus opcode-driven immediate extension (sign, zero, or LUI).
- Decoded fields and operands are captured into an output register behind a valid/ready handshake.
- Sits between instruction fetch (IR) and execute/ALU; operands are held stable while execute stalls.

Parameters:
- DATA_WIDTH, 32, register/operand/immediate width; legal range is 32 or more.
- NUM_REGS, 32, number of architectural registers, 2..32; register 0 is hardwired to zero.
- CNT_WIDTH, 16, width of the decoded-instruction counter.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  instruction is presented.
- instr_ready  out  1  stage can accept an instruction.
- instruction  in  32  MIPS instruction word.
- reg_write  in  1  register-file write enable (writeback).
- write_reg  in  5  writeback register index.
- write_data  in  DATA_WIDTH  writeback data.
- out_valid  out  1  decoded outputs valid.
- out_ready  in  1  execute consumes the decoded outputs.
- opcode  out  6  instruction[31:26].
- rs, rt, rd  out  5 each  instruction[25:21], [20:16], [15:11].
- funct  out  6  instruction[5:0].
- read_data1  out  DATA_WIDTH  value of GPR[rs].
- read_data2  out  DATA_WIDTH  value of GPR[rt].
- immediate  out  DATA_WIDTH  extended immediate.
- decode_count  out  CNT_WIDTH  number of accepted instructions.

Behaviour:
- Reset (async, reset_n=0): every register-file entry is 0; out_valid=0; all output fields are 0; decode_count=0. Reset mid-hold discards the held instruction. instr_ready=1 in the first cycle after release.
- Register file:
  - Written on the rising edge when reg_write=1, write_reg!=0 and write_reg<NUM_REGS.
  - Index 0 and indices >= NUM_REGS always read 0.
  - Writes to index 0 and indices >= NUM_REGS are ignored.
- Handshake:
  - instr_ready = !out_valid || out_ready (combinational).
  - Accept = instr_valid && instr_ready. Latency is 1 cycle: on the accept edge the fields, operands and immediate are captured and out_valid becomes 1.
  - Consume without a new accept: out_valid goes to 0.
  - Consume and accept in the same cycle: out_valid stays 1 and the new data is loaded.
  - Back-to-back throughput is one instruction per clock.
- State: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on out_ready without accept.
  - FULL -> FULL on out_ready with accept, or on hold.
- Hold (FULL, out_ready=0): every output is stable, except operand refresh under the optional feature.
- Immediate extension (imm = instruction[15:0]):
  - opcode 0x0C/0x0D/0x0E (ANDI/ORI/XORI): zero-extend.
  - opcode 0x0F (LUI): imm<<16, zero-extended.
  - All other opcodes: sign-extend to DATA_WIDTH.
- Simultaneous write and accept to the same register, without the optional feature: the captured operand is the pre-write value.
- decode_count increments by 1 per accept and wraps from 2^CNT_WIDTH-1 to 0.
- X-safety: while out_valid=0, output fields hold their last value; consumers must qualify with out_valid.

Optional Feature:
- Macro: DECODE_STAGE_BYPASS_EN.
- Defined:
  - An accept-cycle write whose write_reg matches rs (or rt) of the incoming instruction forwards write_data into read_data1 (or read_data2).
  - While FULL and holding, a write matching the held rs/rt updates the held read_data1/read_data2 at that edge.
  - Index 0 and indices >= NUM_REGS are never forwarded.
- Not defined: no forwarding. Operands are those sampled at the accept edge and remain frozen during hold.

Test Plan:
- Reset and register 0: reset_n=0 mid-hold, then release. Expect out_valid=0, instr_ready=1, decode_count=0. Write reg0=0xDEADBEEF; a decode of rs=0 gives read_data1=0.
- Write/read: write reg5=0x12345678 and reg6=0xFFFF0000. Accept 0x00A63020 (add rd=6, rs=5, rt=6). Next cycle: out_valid=1, read_data1=0x12345678, read_data2=0xFFFF0000, rd=6, funct=0x20.
- Immediates:
  - addi 0x2008FFFC gives immediate=0xFFFFFFFC.
  - ori 0x3508FFFC gives 0x0000FFFC.
  - lui 0x3C081234 gives 0x12340000.
- Backpressure and throughput:
  - out_ready=0 for 3 cycles: outputs are stable, instr_ready=0, the new instruction is not accepted.
  - Then out_ready=1 with instr_valid=1 continuous: one accept per clock; decode_count increments each cycle.
- Bypass: same-cycle write of reg9=0xA5A5A5A5 while accepting an instruction with rs=9.
  - Macro defined: read_data1=0xA5A5A5A5.
  - Macro undefined: read_data1 is the old value.
  - Repeat during hold: the held value refreshes only with the macro defined.
- Depth and counter wrap:
  - NUM_REGS=16: a write to reg20 is ignored and a read of rs=20 returns 0.
  - CNT_WIDTH=4: the 16th accept wraps decode_count to 0.

Source files
------------

// File: rtl/decode_stage_pipe.sv
// MIPS decode stage: register file, immediate extension and a one-deep valid/ready output register.
// Define DECODE_STAGE_BYPASS_EN to forward writeback data into accepted or held operands.
`timescale 1ns/1ps

module decode_stage_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [31:0]           instruction,
  input  logic                  reg_write,
  input  logic [4:0]            write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [5:0]            opcode,
  output logic [4:0]            rs,
  output logic [4:0]            rt,
  output logic [4:0]            rd,
  output logic [5:0]            funct,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2,
  output logic [DATA_WIDTH-1:0] immediate,
  output logic [CNT_WIDTH-1:0]  decode_count
);

  typedef enum logic {EMPTY, FULL} state_t;

  localparam logic [5:0] NUM_REGS_W = 6'(NUM_REGS);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] regs_q [1:NUM_REGS-1];
  logic [DATA_WIDTH-1:0] regs_d [1:NUM_REGS-1];
  logic [5:0]            opcode_q, opcode_d;
  logic [4:0]            rs_q, rs_d;
  logic [4:0]            rt_q, rt_d;
  logic [4:0]            rd_q, rd_d;
  logic [5:0]            funct_q, funct_d;
  logic [DATA_WIDTH-1:0] op1_q, op1_d;
  logic [DATA_WIDTH-1:0] op2_q, op2_d;
  logic [DATA_WIDTH-1:0] imm_q, imm_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic                  accept;
  logic                  write_hit;
  logic [15:0]           imm16;
  logic [DATA_WIDTH-1:0] imm_ext;
  logic [DATA_WIDTH-1:0] rf_rs;
  logic [DATA_WIDTH-1:0] rf_rt;

  assign instr_ready = (state_q == EMPTY) || out_ready;
  assign accept      = instr_valid && instr_ready;
  assign write_hit   = reg_write && (write_reg != 5'd0) && ({1'b0, write_reg} < NUM_REGS_W);

  // Entry 0 has no storage; indices outside the file fall through to zero.
  always_comb begin
    rf_rs = '0;
    rf_rt = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (instruction[25:21] == 5'(i)) rf_rs = regs_q[i];
      if (instruction[20:16] == 5'(i)) rf_rt = regs_q[i];
    end
  end

  always_comb begin
    regs_d = regs_q;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (write_hit && (write_reg == 5'(i))) regs_d[i] = write_data;
    end
  end

  always_comb begin
    imm16 = instruction[15:0];
    case (instruction[31:26])
      6'h0C, 6'h0D, 6'h0E: imm_ext = DATA_WIDTH'(imm16);
      6'h0F:               imm_ext = DATA_WIDTH'({imm16, 16'h0000});
      default:             imm_ext = {{(DATA_WIDTH-16){imm16[15]}}, imm16};
    endcase
  end

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    rd_d     = rd_q;
    funct_d  = funct_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    imm_d    = imm_q;
    cnt_d    = cnt_q;
    if (accept) begin
      state_d  = FULL;
      opcode_d = instruction[31:26];
      rs_d     = instruction[25:21];
      rt_d     = instruction[20:16];
      rd_d     = instruction[15:11];
      funct_d  = instruction[5:0];
      op1_d    = rf_rs;
      op2_d    = rf_rt;
      imm_d    = imm_ext;
      cnt_d    = cnt_q + CNT_WIDTH'(1);
`ifdef DECODE_STAGE_BYPASS_EN
      if (write_hit && (write_reg == instruction[25:21])) op1_d = write_data;
      if (write_hit && (write_reg == instruction[20:16])) op2_d = write_data;
`endif
    end else if (state_q == FULL) begin
      if (out_ready) begin
        state_d = EMPTY;
      end else begin
`ifdef DECODE_STAGE_BYPASS_EN
        // Held operands track writeback so execute sees fresh values when it resumes.
        if (write_hit && (write_reg == rs_q)) op1_d = write_data;
        if (write_hit && (write_reg == rt_q)) op2_d = write_data;
`endif
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= EMPTY;
      opcode_q <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
      funct_q  <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      imm_q    <= '0;
      cnt_q    <= '0;
      for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      rd_q     <= rd_d;
      funct_q  <= funct_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      imm_q    <= imm_d;
      cnt_q    <= cnt_d;
      for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign out_valid    = (state_q == FULL);
  assign opcode       = opcode_q;
  assign rs           = rs_q;
  assign rt           = rt_q;
  assign rd           = rd_q;
  assign funct        = funct_q;
  assign read_data1   = op1_q;
  assign read_data2   = op2_q;
  assign immediate    = imm_q;
  assign decode_count = cnt_q;

endmodule
